// File: rtl/debug_pkg.sv
// Shared debug-unit definitions: byte/word geometry and TX serialiser state encoding.
package debug_pkg;

  localparam int DBIT   = 8;
  localparam int NBYTES = 4;
  localparam int WORD_W = DBIT * NBYTES;

  typedef enum logic [0:0] {
    TX_IDLE = 1'b0,
    TX_SEND = 1'b1
  } tx_state_t;

  // Width of a byte-lane counter; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_rx_assembler.sv
// Packs bytes popped from a first-word-fall-through RX FIFO into words, LSB first,
// and discards a partial word when the inter-byte gap exceeds TIMEOUT cycles.
module uart_rx_assembler #(
  parameter int DBIT    = debug_pkg::DBIT,
  parameter int NBYTES  = debug_pkg::NBYTES,
  parameter int TIMEOUT = 50000,
  parameter int TO_BITS = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     rx_empty,
  input  logic [DBIT-1:0]          r_data,
  output logic                     rd_uart,
  output logic                     rx_word_valid,
  output logic [DBIT*NBYTES-1:0]   rx_word,
  input  logic                     rx_word_ready,
  output logic                     rx_frame_err
);
  import debug_pkg::*;

  localparam int                 CW        = cnt_width(NBYTES);
  localparam logic [CW-1:0]      LAST_LANE = CW'(NBYTES - 1);
  localparam bit                 TO_EN     = (TIMEOUT != 0);
  localparam logic [TO_BITS-1:0] TO_LAST   = TO_EN ? TO_BITS'(TIMEOUT - 1) : '0;

  logic [CW-1:0]            rx_cnt_reg;
  logic [TO_BITS-1:0]       to_cnt_reg;
  logic [DBIT*NBYTES-1:0]   word_reg;
  logic                     valid_reg;
  logic                     err_reg;
  logic                     pop;
  logic [NBYTES-1:0]        lane_hit;

  // Pop whenever a byte is at the FIFO head and no finished word is waiting.
  assign pop = ~rx_empty & ~valid_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NBYTES; gi++) begin : g_lane
      assign lane_hit[gi] = pop && (rx_cnt_reg == CW'(gi));
    end
  endgenerate

  // Capture the popped byte into the lane selected by the byte counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      word_reg <= '0;
    end else begin
      for (int i = 0; i < NBYTES; i++) begin
        if (lane_hit[i]) word_reg[i*DBIT +: DBIT] <= r_data;
      end
    end
  end

  // Byte counter, word-valid handshake and inter-byte timeout; a pop beats a timeout.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_cnt_reg <= '0;
      to_cnt_reg <= '0;
      valid_reg  <= 1'b0;
      err_reg    <= 1'b0;
    end else begin
      err_reg <= 1'b0;
      if (valid_reg && rx_word_ready) valid_reg <= 1'b0;
      if (pop) begin
        to_cnt_reg <= '0;
        if (rx_cnt_reg == LAST_LANE) begin
          rx_cnt_reg <= '0;
          valid_reg  <= 1'b1;
        end else begin
          rx_cnt_reg <= rx_cnt_reg + 1'b1;
        end
      end else if (TO_EN && (rx_cnt_reg != '0)) begin
        if (to_cnt_reg == TO_LAST) begin
          rx_cnt_reg <= '0;
          to_cnt_reg <= '0;
          err_reg    <= 1'b1;
        end else begin
          to_cnt_reg <= to_cnt_reg + 1'b1;
        end
      end
    end
  end

  assign rd_uart       = pop;
  assign rx_word_valid = valid_reg;
  assign rx_word       = word_reg;
  assign rx_frame_err  = err_reg;

endmodule

// File: rtl/uart_word_bridge.sv
// Bridges UART byte FIFOs and the debug unit's word interface: RX bytes are packed
// into words, TX words are serialised into bytes, both LSB first.
module uart_word_bridge #(
  parameter int DBIT    = debug_pkg::DBIT,
  parameter int NBYTES  = debug_pkg::NBYTES,
  parameter int TIMEOUT = 50000,
  parameter int TO_BITS = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     rx_empty,
  input  logic [DBIT-1:0]          r_data,
  output logic                     rd_uart,
  input  logic                     tx_full,
  output logic                     wr_uart,
  output logic [DBIT-1:0]          w_data,
  output logic                     rx_word_valid,
  output logic [DBIT*NBYTES-1:0]   rx_word,
  input  logic                     rx_word_ready,
  output logic                     rx_frame_err,
  input  logic                     tx_word_valid,
  input  logic [DBIT*NBYTES-1:0]   tx_word,
  output logic                     tx_word_ready,
  output logic                     tx_busy
);
  import debug_pkg::*;

  localparam int            CW        = cnt_width(NBYTES);
  localparam logic [CW-1:0] LAST_BYTE = CW'(NBYTES - 1);

  uart_rx_assembler #(
    .DBIT    (DBIT),
    .NBYTES  (NBYTES),
    .TIMEOUT (TIMEOUT),
    .TO_BITS (TO_BITS)
  ) u_rx (
    .clk           (clk),
    .reset         (reset),
    .rx_empty      (rx_empty),
    .r_data        (r_data),
    .rd_uart       (rd_uart),
    .rx_word_valid (rx_word_valid),
    .rx_word       (rx_word),
    .rx_word_ready (rx_word_ready),
    .rx_frame_err  (rx_frame_err)
  );

  tx_state_t                state_reg;
  logic [DBIT*NBYTES-1:0]   shift_reg;
  logic [CW-1:0]            tx_cnt_reg;
  logic                     ready_reg;
  logic                     busy_reg;
  logic                     push;

  // A byte leaves whenever we are sending and the TX FIFO has room.
  assign push = (state_reg == TX_SEND) & ~tx_full;

  // TX serialiser: accept a word in IDLE, push its bytes LSB first in SEND.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= TX_IDLE;
      shift_reg  <= '0;
      tx_cnt_reg <= '0;
      ready_reg  <= 1'b1;
      busy_reg   <= 1'b0;
    end else begin
      case (state_reg)
        TX_IDLE: begin
          if (tx_word_valid) begin
            shift_reg  <= tx_word;
            tx_cnt_reg <= '0;
            state_reg  <= TX_SEND;
            ready_reg  <= 1'b0;
            busy_reg   <= 1'b1;
          end
        end
        TX_SEND: begin
          if (push) begin
            shift_reg <= shift_reg >> DBIT;
            if (tx_cnt_reg == LAST_BYTE) begin
              tx_cnt_reg <= '0;
              state_reg  <= TX_IDLE;
              ready_reg  <= 1'b1;
              busy_reg   <= 1'b0;
            end else begin
              tx_cnt_reg <= tx_cnt_reg + 1'b1;
            end
          end
        end
        default: state_reg <= TX_IDLE;
      endcase
    end
  end

  assign wr_uart       = push;
  assign w_data        = shift_reg[DBIT-1:0];
  assign tx_word_ready = ready_reg;
  assign tx_busy       = busy_reg;

endmodule
